// File: rtl/dac_pkg.sv
// Shared constants and types for the serial DAC transmitter.
package dac_pkg;

  localparam int unsigned FRAME_W     = 16;
  localparam int unsigned SAMPLE_W    = 15;
  localparam int unsigned BIT_CNT_W   = 4;
  localparam int unsigned DEF_CLK_DIV = 4;
  localparam int unsigned DEF_CS_GAP  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// SCLK generator: toggles every CLK_DIV enabled cycles, starting low.
// The strobes mark the clk edge on which sclk_o changes, so the caller
// can update its own registers on that very edge.
module dac_sclk_gen
  import dac_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int unsigned           CNT_W    = cnt_width(CLK_DIV);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             phase_end;

  // Half-period bookkeeping; everything collapses to zero when disabled.
  always_comb begin
    cnt_d     = cnt_q;
    sclk_d    = sclk_q;
    phase_end = en_i && (cnt_q == CNT_LAST);
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (phase_end) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter and clock registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o     = sclk_q;
  assign rise_stb_o = phase_end && !sclk_q;
  assign fall_stb_o = phase_end &&  sclk_q;

endmodule

// File: rtl/dac_spi_tx.sv
// Serial DAC transmitter: one 16-bit MSB-first SPI frame per sample
// handshake, followed by an enforced chip-select-high gap.
module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned CS_GAP   = DEF_CS_GAP,
  parameter logic        CTRL_BIT = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                dac_cs_n,
  output logic                dac_sclk,
  output logic                dac_mosi,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned          GAP_W    = cnt_width(CS_GAP);
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_W - 1);

  state_e               state_q;
  logic [FRAME_W-1:0]   shift_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [GAP_W-1:0]     gap_cnt_q;
  logic                 last_q;
  logic                 cs_n_q;
  logic                 mosi_q;
  logic                 busy_q;
  logic                 frame_done_q;

  logic                 sclk_en;
  logic                 rise_stb;
  logic                 fall_stb;

  assign sclk_en = (state_q == SHIFT);

  dac_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk        (clk),
    .rst        (rst),
    .en_i       (sclk_en),
    .sclk_o     (dac_sclk),
    .rise_stb_o (rise_stb),
    .fall_stb_o (fall_stb)
  );

  // Frame FSM with shift register, bit/gap counters and registered outputs.
  // last_q is armed on the rising edge of bit 15 so the closing falling
  // edge only needs a single flag to decide between shifting and ending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      last_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      mosi_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sample_valid) begin
            shift_q   <= {CTRL_BIT, sample};
            bit_cnt_q <= '0;
            last_q    <= 1'b0;
            cs_n_q    <= 1'b0;
            mosi_q    <= CTRL_BIT;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (rise_stb) begin
            last_q <= (bit_cnt_q == BIT_LAST);
          end
          if (fall_stb) begin
            shift_q <= shift_q << 1;
            if (last_q) begin
              cs_n_q       <= 1'b1;
              mosi_q       <= 1'b0;
              frame_done_q <= 1'b1;
              gap_cnt_q    <= '0;
              state_q      <= GAP;
            end else begin
              mosi_q    <= shift_q[FRAME_W-2];
              bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample_ready = (state_q == IDLE);
  assign dac_cs_n     = cs_n_q;
  assign dac_mosi     = mosi_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: instance A (CLK_DIV=2, CS_GAP=2, CTRL_BIT=0) is the
// main target; instance B (CLK_DIV=1, CS_GAP=1, CTRL_BIT=1) shares inputs and
// is scoreboarded against every handshake it accepts.
`timescale 1ns/1ps
module tb_dac_spi_tx;

  localparam int unsigned CD      = 2;
  localparam int unsigned GAPC    = 2;
  localparam int unsigned SPACING = 1 + 32 * CD + GAPC;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] sample;
  logic        sample_valid;

  logic rdy_a, cs_a, sclk_a, mosi_a, busy_a, fd_a;
  logic rdy_b, cs_b, sclk_b, mosi_b, busy_b, fd_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  dac_spi_tx #(.CLK_DIV(CD), .CS_GAP(GAPC), .CTRL_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .sample_ready(rdy_a), .dac_cs_n(cs_a), .dac_sclk(sclk_a),
    .dac_mosi(mosi_a), .busy(busy_a), .frame_done(fd_a));

  dac_spi_tx #(.CLK_DIV(1), .CS_GAP(1), .CTRL_BIT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .sample_ready(rdy_b), .dac_cs_n(cs_b), .dac_sclk(sclk_b),
    .dac_mosi(mosi_b), .busy(busy_b), .frame_done(fd_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: frame content is just the control bit ahead of the sample.
  function automatic logic [15:0] exp_frame(input logic ctrl, input logic [14:0] s);
    return {ctrl, s};
  endfunction

  // ---------------- bus monitor for instance A (negedge sampled) ----------
  logic        sclk_prev_a = 1'b0, cs_prev_a = 1'b1, mosi_prev_a = 1'b0;
  logic [15:0] sh_a = '0;
  int          nb_a = 0;
  logic [15:0] frames_a[$];
  int          rise_cyc_a[$];
  int          fd_cyc_a[$];
  int          csfall_cyc_a[$];
  int          partial_a = 0;
  int          mosi_viol_a = 0;

  always @(negedge clk) begin
    if (mosi_a !== mosi_prev_a && sclk_a === 1'b1) mosi_viol_a++;
    if (cs_a === 1'b0 && cs_prev_a === 1'b1) begin
      csfall_cyc_a.push_back(cyc);
      nb_a = 0;
      sh_a = '0;
    end
    if (sclk_a === 1'b1 && sclk_prev_a === 1'b0) begin
      sh_a = {sh_a[14:0], mosi_a};
      nb_a++;
      rise_cyc_a.push_back(cyc);
    end
    if (cs_a === 1'b1 && cs_prev_a === 1'b0) begin
      if (nb_a == 16) frames_a.push_back(sh_a);
      else partial_a++;
    end
    if (fd_a === 1'b1) fd_cyc_a.push_back(cyc);
    sclk_prev_a = sclk_a;
    cs_prev_a   = cs_a;
    mosi_prev_a = mosi_a;
  end

  // ---------------- predictor and monitor for instance B -----------------
  logic [15:0] exp_b[$];
  logic [15:0] got_b_frame[$];
  int          got_b_bits[$];
  logic        sclk_prev_b = 1'b0, cs_prev_b = 1'b1;
  logic [15:0] sh_b = '0;
  int          nb_b = 0;
  int          fd_b_cnt = 0;

  always @(posedge clk) begin
    if (rst === 1'b0 && sample_valid === 1'b1 && rdy_b === 1'b1)
      exp_b.push_back(exp_frame(1'b1, sample));
  end

  always @(negedge clk) begin
    if (cs_b === 1'b0 && cs_prev_b === 1'b1) begin
      nb_b = 0;
      sh_b = '0;
    end
    if (sclk_b === 1'b1 && sclk_prev_b === 1'b0) begin
      sh_b = {sh_b[14:0], mosi_b};
      nb_b++;
    end
    if (cs_b === 1'b1 && cs_prev_b === 1'b0) begin
      got_b_frame.push_back(sh_b);
      got_b_bits.push_back(nb_b);
    end
    if (fd_b === 1'b1) fd_b_cnt++;
    sclk_prev_b = sclk_b;
    cs_prev_b   = cs_b;
  end

  // ---------------- helpers ----------------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    frames_a.delete();
    rise_cyc_a.delete();
    fd_cyc_a.delete();
    csfall_cyc_a.delete();
    partial_a   = 0;
    mosi_viol_a = 0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  // Waits (bounded) for A to be ready, then presents one sample for one edge.
  task automatic do_handshake(input logic [14:0] s, output int t0);
    int n = 0;
    while (rdy_a !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    if (rdy_a !== 1'b1) begin
      total++; bad++;
      $display("FAIL hs_wait: sample_ready=%b after %0d cycles, required 1", rdy_a, n);
    end
    sample       = s;
    sample_valid = 1'b1;
    step();
    t0           = cyc;
    sample_valid = 1'b0;
  endtask

  // ---------------- tests -------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; sample_valid = 1'b0; sample = '0;
    repeat (3) step();
    total++; if (rdy_a !== 1'b1)  begin bad++; $display("FAIL rst_ready: got %b want 1", rdy_a); end
    total++; if (cs_a !== 1'b1)   begin bad++; $display("FAIL rst_cs_n: got %b want 1", cs_a); end
    total++; if (sclk_a !== 1'b0) begin bad++; $display("FAIL rst_sclk: got %b want 0", sclk_a); end
    total++; if (mosi_a !== 1'b0) begin bad++; $display("FAIL rst_mosi: got %b want 0", mosi_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    total++; if (fd_a !== 1'b0)   begin bad++; $display("FAIL rst_frame_done: got %b want 0", fd_a); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int t0;
    int rdy_cyc = -1;
    int busy_fall = -1;
    logic cs0, mosi0, busy0, rdy0;
    clear_mon();
    do_handshake(15'h5555, t0);
    cs0 = cs_a; mosi0 = mosi_a; busy0 = busy_a; rdy0 = rdy_a;
    while (cyc < t0 + 32 * CD + GAPC + 4) begin
      step();
      if (rdy_cyc < 0 && rdy_a === 1'b1) rdy_cyc = cyc;
      if (busy_fall < 0 && busy_a === 1'b0) busy_fall = cyc;
    end
    total++; if (cs0 !== 1'b0)   begin bad++; $display("FAIL single_cs_fall: cs_n=%b want 0 at T+1", cs0); end
    total++; if (mosi0 !== 1'b0) begin bad++; $display("FAIL single_bit15: mosi=%b want 0", mosi0); end
    total++; if (busy0 !== 1'b1 || rdy0 !== 1'b0) begin bad++; $display("FAIL single_busy: busy=%b ready=%b want 1/0", busy0, rdy0); end
    total++; if (frames_a.size() != 1 || frames_a[0] !== exp_frame(1'b0, 15'h5555)) begin
      bad++; $display("FAIL single_frame: %0d frames, first=%h want 1 frame %h", frames_a.size(),
                      (frames_a.size() > 0) ? frames_a[0] : 16'hxxxx, exp_frame(1'b0, 15'h5555));
    end
    total++; if (rise_cyc_a.size() != 16) begin bad++; $display("FAIL single_rises: got %0d want 16", rise_cyc_a.size()); end
    total++; if (rise_cyc_a.size() == 0 || rise_cyc_a[0] != t0 + CD) begin
      bad++; $display("FAIL single_first_rise: at T+%0d want T+%0d", (rise_cyc_a.size() > 0) ? rise_cyc_a[0] - t0 : -1, CD);
    end
    total++; if (fd_cyc_a.size() != 1 || fd_cyc_a[0] != t0 + 32 * CD) begin
      bad++; $display("FAIL single_frame_done: %0d pulses, first at T+%0d want 1 at T+%0d", fd_cyc_a.size(),
                      (fd_cyc_a.size() > 0) ? fd_cyc_a[0] - t0 : -1, 32 * CD);
    end
    total++; if (rdy_cyc != t0 + 32 * CD + GAPC) begin
      bad++; $display("FAIL single_ready_back: at T+%0d want T+%0d", rdy_cyc - t0, 32 * CD + GAPC);
    end
    total++; if (busy_fall != t0 + 32 * CD + GAPC) begin
      bad++; $display("FAIL single_busy_fall: at T+%0d want T+%0d", busy_fall - t0, 32 * CD + GAPC);
    end
    total++; if (mosi_viol_a != 0) begin bad++; $display("FAIL single_mosi_stable: %0d changes while sclk high, want 0", mosi_viol_a); end
  endtask

  task automatic test_ctrl_bit();
    int t0;
    int base;
    logic [14:0] vals [2];
    vals[0] = 15'h0000;
    vals[1] = 15'h7FFF;
    for (int i = 0; i < 2; i++) begin
      clear_mon();
      base = got_b_frame.size();
      do_handshake(vals[i], t0);
      wait_until(t0 + 32 * CD + GAPC + 2);
      total++; if (frames_a.size() != 1 || frames_a[0] !== exp_frame(1'b0, vals[i])) begin
        bad++; $display("FAIL ctrl0_frame: %0d frames, first=%h want %h", frames_a.size(),
                        (frames_a.size() > 0) ? frames_a[0] : 16'hxxxx, exp_frame(1'b0, vals[i]));
      end
      total++; if (got_b_frame.size() != base + 1 || got_b_frame[base] !== exp_frame(1'b1, vals[i])) begin
        bad++; $display("FAIL ctrl1_frame: %0d new frames, first=%h want %h", got_b_frame.size() - base,
                        (got_b_frame.size() > base) ? got_b_frame[base] : 16'hxxxx, exp_frame(1'b1, vals[i]));
      end
    end
  endtask

  task automatic test_random();
    int t0;
    logic [14:0] s;
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      s = 15'($urandom);
      do_handshake(s, t0);
      wait_until(t0 + 32 * CD + GAPC + 1);
      total++; if (frames_a.size() != 1 || frames_a[0] !== exp_frame(1'b0, s)) begin
        bad++; $display("FAIL random_frame[%0d]: %0d frames, first=%h want %h", i, frames_a.size(),
                        (frames_a.size() > 0) ? frames_a[0] : 16'hxxxx, exp_frame(1'b0, s));
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int n = 0;
    clear_mon();
    while (rdy_a !== 1'b1 && n < 300) begin step(); n++; end
    sample = 15'h0001; sample_valid = 1'b1;
    step();
    t0 = cyc;
    sample = 15'h4000;
    n = 0;
    while (csfall_cyc_a.size() < 2 && n < 300) begin step(); n++; end
    sample_valid = 1'b0;
    n = 0;
    while (frames_a.size() < 2 && n < 300) begin step(); n++; end
    total++; if (csfall_cyc_a.size() != 2) begin
      bad++; $display("FAIL b2b_count: %0d frames started, want 2", csfall_cyc_a.size());
    end else begin
      total++; if (csfall_cyc_a[0] != t0) begin bad++; $display("FAIL b2b_first: cs fall at T+%0d want T+0", csfall_cyc_a[0] - t0); end
      total++; if (csfall_cyc_a[1] - csfall_cyc_a[0] != SPACING) begin
        bad++; $display("FAIL b2b_spacing: %0d cycles want %0d", csfall_cyc_a[1] - csfall_cyc_a[0], SPACING);
      end
    end
    total++; if (frames_a.size() != 2 || frames_a[0] !== 16'h0001 || frames_a[1] !== 16'h4000) begin
      bad++; $display("FAIL b2b_frames: %0d frames %h %h want 0001 4000", frames_a.size(),
                      (frames_a.size() > 0) ? frames_a[0] : 16'hxxxx, (frames_a.size() > 1) ? frames_a[1] : 16'hxxxx);
    end
  endtask

  task automatic test_sample_toggle();
    int t0;
    int n = 0;
    logic [14:0] s0;
    clear_mon();
    s0 = 15'($urandom);
    do_handshake(s0, t0);
    while (fd_cyc_a.size() == 0 && n < 200) begin
      sample = 15'($urandom);
      step();
      n++;
    end
    wait_until(t0 + 32 * CD + GAPC + 1);
    total++; if (frames_a.size() != 1 || frames_a[0] !== exp_frame(1'b0, s0)) begin
      bad++; $display("FAIL toggle_frame: %0d frames, first=%h want %h", frames_a.size(),
                      (frames_a.size() > 0) ? frames_a[0] : 16'hxxxx, exp_frame(1'b0, s0));
    end
  endtask

  task automatic test_valid_ignored();
    int t0;
    logic [14:0] s0;
    clear_mon();
    s0 = 15'($urandom);
    do_handshake(s0, t0);
    wait_until(t0 + 10);
    sample = ~s0; sample_valid = 1'b1;
    step();
    total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL ign_shift_ready: got %b want 0", rdy_a); end
    sample_valid = 1'b0;
    wait_until(t0 + 32 * CD);
    sample = 15'($urandom); sample_valid = 1'b1;
    total++; if (rdy_a !== 1'b0 || cs_a !== 1'b1) begin
      bad++; $display("FAIL ign_gap_state: ready=%b cs_n=%b want 0/1", rdy_a, cs_a);
    end
    step();
    total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL ign_gap_ready: got %b want 0", rdy_a); end
    step();
    sample_valid = 1'b0;
    wait_until(t0 + SPACING + 40);
    total++; if (csfall_cyc_a.size() != 1 || frames_a.size() != 1 || frames_a[0] !== exp_frame(1'b0, s0)) begin
      bad++; $display("FAIL ign_frame: starts=%0d frames=%0d first=%h want 1/1 %h", csfall_cyc_a.size(), frames_a.size(),
                      (frames_a.size() > 0) ? frames_a[0] : 16'hxxxx, exp_frame(1'b0, s0));
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    logic [14:0] s0;
    logic [14:0] s1;
    clear_mon();
    s0 = 15'($urandom);
    do_handshake(s0, t0);
    wait_until(t0 + 2 * CD * 7 + CD);
    total++; if (sclk_a !== 1'b1 || cs_a !== 1'b0) begin
      bad++; $display("FAIL rmid_pre: sclk=%b cs_n=%b want 1/0 in bit 7 high phase", sclk_a, cs_a);
    end
    #2 rst = 1'b1;
    #1;
    total++; if (cs_a !== 1'b1 || sclk_a !== 1'b0 || busy_a !== 1'b0 || mosi_a !== 1'b0 || rdy_a !== 1'b1 || busy_b !== 1'b0) begin
      bad++; $display("FAIL rmid_async: cs_n=%b sclk=%b busy=%b mosi=%b ready=%b busy_b=%b want 1 0 0 0 1 0",
                      cs_a, sclk_a, busy_a, mosi_a, rdy_a, busy_b);
    end
    repeat (3) step();
    rst = 1'b0;
    wait_until(t0 + SPACING + 10);
    total++; if (fd_cyc_a.size() != 0 || frames_a.size() != 0 || partial_a != 1) begin
      bad++; $display("FAIL rmid_abandon: pulses=%0d frames=%0d partials=%0d want 0 0 1", fd_cyc_a.size(), frames_a.size(), partial_a);
    end
    total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %b want 1", rdy_a); end
    clear_mon();
    s1 = 15'($urandom);
    do_handshake(s1, t0);
    wait_until(t0 + 32 * CD + GAPC + 1);
    total++; if (frames_a.size() != 1 || frames_a[0] !== exp_frame(1'b0, s1)) begin
      bad++; $display("FAIL rmid_next_frame: %0d frames, first=%h want %h", frames_a.size(),
                      (frames_a.size() > 0) ? frames_a[0] : 16'hxxxx, exp_frame(1'b0, s1));
    end
  endtask

  // Every handshake B accepted must appear as one CS-low episode; full ones
  // must carry the predicted frame, one frame_done each.
  task automatic test_b_scoreboard();
    int full = 0;
    int errs = 0;
    repeat (60) step();
    total++; if (got_b_frame.size() != exp_b.size()) begin
      bad++; $display("FAIL b_count: %0d frames seen, want %0d handshakes", got_b_frame.size(), exp_b.size());
    end
    for (int i = 0; i < got_b_frame.size() && i < exp_b.size(); i++) begin
      if (got_b_bits[i] == 16) begin
        full++;
        if (got_b_frame[i] !== exp_b[i]) begin
          errs++;
          $display("FAIL b_frame[%0d]: got %h want %h", i, got_b_frame[i], exp_b[i]);
        end
      end
    end
    total++; if (errs != 0 || full < 5) begin
      bad++; $display("FAIL b_frames: %0d wrong of %0d full frames, want 0 wrong of at least 5", errs, full);
    end
    total++; if (fd_b_cnt != full) begin
      bad++; $display("FAIL b_frame_done: %0d pulses want %0d", fd_b_cnt, full);
    end
  endtask

  initial begin
    rst = 1'b1;
    sample_valid = 1'b0;
    sample = '0;
    test_reset();
    test_single();
    test_ctrl_bit();
    test_random();
    test_back_to_back();
    test_sample_toggle();
    test_valid_ignored();
    test_reset_mid();
    test_b_scoreboard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
